// File: rtl/mac_accum_pkg.sv
// Shared definitions for the pipelined MAC accumulator: operation codes,
// default slice width and a small decode helper.
package mac_accum_pkg;

   localparam int W_SLICE_DFLT = 16;
   localparam int ACC_W        = 2 * W_SLICE_DFLT;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_LOAD = 2'b10,
      OP_HOLD = 2'b11
   } op_e;

   // True for the operations that go through the add/sub slices.
   function automatic logic op_is_arith(input op_e op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/mac_accum_pipe_slice.sv
// Combinational add/sub slice. CI and CO share one meaning per operation:
// on ADD they are carry-in/carry-out, on SUB they are borrow-in/borrow-out,
// so slices cascade directly without any glue inversion.
module accum_slice16 #(
   parameter int W = 16
) (
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         SUB,
   input  logic         CI,
   output logic [W-1:0] SUM,
   output logic         CO
);

   logic [W-1:0] b_eff;
   logic         c_eff;
   logic [W:0]   ext;

   // A - B - borrow is computed as A + ~B + ~borrow; the raw carry is then
   // inverted back into a borrow.
   always_comb begin
      b_eff = SUB ? ~B : B;
      c_eff = CI ^ SUB;
      ext   = {1'b0, A} + {1'b0, b_eff} + {{W{1'b0}}, c_eff};
   end

   assign SUM = ext[W-1:0];
   assign CO  = ext[W] ^ SUB;

endmodule

// File: rtl/mac_accum_pipe.sv
// Two-stage 32-bit accumulator. Stage 1 updates the low half and registers
// the cascade carry/borrow; stage 2 updates the high half with it and
// produces the result beat. Per-half skew is a constant one cycle, so
// back-to-back beats see a consistent accumulator without forwarding.
//
// Handshake: an input beat transfers on a rising edge where
// IN_VALID & IN_READY; a result beat transfers on a rising edge where
// OUT_VALID & OUT_READY. The pipeline advances only when the output slot
// is empty or being drained (adv), and CLEAR blocks acceptance.
module mac_accum_pipe
   import mac_accum_pkg::*;
#(
   parameter int W_SLICE    = W_SLICE_DFLT,
   parameter bit STICKY_OVF = 1'b1
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 IN_VALID,
   output logic                 IN_READY,
   input  logic [1:0]           OP,
   input  logic [2*W_SLICE-1:0] OPND,
   input  logic                 CLEAR,
   output logic                 OUT_VALID,
   input  logic                 OUT_READY,
   output logic [2*W_SLICE-1:0] ACC_OUT,
   output logic                 CO,
   output logic                 OVF
);

   localparam int AW = 2 * W_SLICE;

   op_e                 op_in;
   logic                adv;
   logic                accept;

   // stage 1 state
   logic [W_SLICE-1:0]  acc_lo_q, acc_lo_d;
   logic                c1_q, c1_d;
   op_e                 s1_op_q;
   logic [W_SLICE-1:0]  s1_opnd_hi_q;
   logic [W_SLICE-1:0]  s1_lo_q;
   logic                s1_valid_q;

   // stage 2 state
   logic [W_SLICE-1:0]  acc_hi_q, acc_hi_d;
   logic [AW-1:0]       acc_out_q;
   logic                co_q, co_d;
   logic                ovf_q, ovf_d;
   logic                beat_ovf;
   logic                out_valid_q;

   // slice connections
   logic                lo_sub, hi_sub;
   logic [W_SLICE-1:0]  lo_sum, hi_sum;
   logic                lo_co, hi_co;
   logic                a_s, b_s, r_s;

   assign op_in    = op_e'(OP);
   assign adv      = ~out_valid_q | OUT_READY;
   assign IN_READY = adv & ~CLEAR;
   assign accept   = IN_VALID & IN_READY;

   assign lo_sub = (op_in == OP_SUB);
   assign hi_sub = (s1_op_q == OP_SUB);

   accum_slice16 #(.W(W_SLICE)) u_slice_lo (
      .A   (acc_lo_q),
      .B   (OPND[W_SLICE-1:0]),
      .SUB (lo_sub),
      .CI  (1'b0),
      .SUM (lo_sum),
      .CO  (lo_co)
   );

   accum_slice16 #(.W(W_SLICE)) u_slice_hi (
      .A   (acc_hi_q),
      .B   (s1_opnd_hi_q),
      .SUB (hi_sub),
      .CI  (c1_q),
      .SUM (hi_sum),
      .CO  (hi_co)
   );

   // Stage 1 next state: low half and cascade carry for the incoming beat.
   always_comb begin
      acc_lo_d = acc_lo_q;
      c1_d     = 1'b0;
      if (op_is_arith(op_in)) begin
         acc_lo_d = lo_sum;
         c1_d     = lo_co;
      end else if (op_in == OP_LOAD) begin
         acc_lo_d = OPND[W_SLICE-1:0];
      end
   end

   // Stage 2 next state: high half, top carry/borrow and signed overflow.
   always_comb begin
      acc_hi_d = acc_hi_q;
      co_d     = 1'b0;
      beat_ovf = 1'b0;
      a_s      = acc_hi_q[W_SLICE-1];
      b_s      = s1_opnd_hi_q[W_SLICE-1];
      r_s      = hi_sum[W_SLICE-1];
      case (s1_op_q)
         OP_ADD: begin
            acc_hi_d = hi_sum;
            co_d     = hi_co;
            beat_ovf = (a_s == b_s) && (r_s != a_s);
         end
         OP_SUB: begin
            acc_hi_d = hi_sum;
            co_d     = hi_co;
            beat_ovf = (a_s != b_s) && (r_s != a_s);
         end
         OP_LOAD: acc_hi_d = s1_opnd_hi_q;
         default: acc_hi_d = acc_hi_q;
      endcase
      ovf_d = STICKY_OVF ? (ovf_q | beat_ovf) : beat_ovf;
   end

   // Stage 1 registers: capture an accepted beat, bubble on an idle advance.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         acc_lo_q     <= '0;
         c1_q         <= 1'b0;
         s1_op_q      <= OP_ADD;
         s1_opnd_hi_q <= '0;
         s1_lo_q      <= '0;
         s1_valid_q   <= 1'b0;
      end else if (CLEAR) begin
         acc_lo_q   <= '0;
         c1_q       <= 1'b0;
         s1_valid_q <= 1'b0;
      end else if (adv) begin
         if (accept) begin
            acc_lo_q     <= acc_lo_d;
            c1_q         <= c1_d;
            s1_op_q      <= op_in;
            s1_opnd_hi_q <= OPND[AW-1:W_SLICE];
            s1_lo_q      <= acc_lo_d;
            s1_valid_q   <= 1'b1;
         end else begin
            s1_valid_q <= 1'b0;
         end
      end
   end

   // Stage 2 registers: commit the high half and present the result beat.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         acc_hi_q    <= '0;
         acc_out_q   <= '0;
         co_q        <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (CLEAR) begin
         acc_hi_q    <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (adv) begin
         if (s1_valid_q) begin
            acc_hi_q    <= acc_hi_d;
            acc_out_q   <= {acc_hi_d, s1_lo_q};
            co_q        <= co_d;
            ovf_q       <= ovf_d;
            out_valid_q <= 1'b1;
         end else begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign OUT_VALID = out_valid_q;
   assign ACC_OUT   = acc_out_q;
   assign CO        = co_q;
   assign OVF       = ovf_q;

endmodule

// File: tb/tb_mac_accum_pipe.sv
// Directed bench for mac_accum_pipe. Result beats are captured as
// {OVF, CO, ACC_OUT} whenever a beat transfers and compared in order
// against hand-computed expectations.
module tb_mac_accum_pipe;
   import mac_accum_pkg::*;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        IN_VALID;
   logic        IN_READY;
   logic [1:0]  OP;
   logic [31:0] OPND;
   logic        CLEAR;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [31:0] ACC_OUT;
   logic        CO;
   logic        OVF;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [33:0] got_q[$];
   logic [33:0] exp_q[$];

   mac_accum_pipe #(.W_SLICE(16), .STICKY_OVF(1'b1)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .OP        (OP),
      .OPND      (OPND),
      .CLEAR     (CLEAR),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .ACC_OUT   (ACC_OUT),
      .CO        (CO),
      .OVF       (OVF)
   );

   // clock and watchdog
   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // output monitor: record every transferred result beat
   always @(negedge CLK) begin
      if (RST_N && OUT_VALID && OUT_READY)
         got_q.push_back({OVF, CO, ACC_OUT});
   end

   // driver: offer one beat, wait (bounded) for acceptance
   task automatic send(input logic [1:0] op, input logic [31:0] opnd);
      logic ok;
      ok       = 1'b0;
      IN_VALID = 1'b1;
      OP       = op;
      OPND     = opnd;
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         if (IN_READY) begin
            ok = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL send_accept: IN_READY got 0 want 1 (op %0d opnd %h)", op, opnd);
      end
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // bounded wait for n captured result beats
   task automatic wait_got(input int n);
      for (int i = 0; i < 100; i++) begin
         if (got_q.size() >= n) break;
         @(posedge CLK);
         #1;
      end
      n_cmp++;
      if (got_q.size() < n) begin
         n_fail++;
         $display("FAIL wait_out: beats got %0d want %0d", got_q.size(), n);
      end
   endtask

   task automatic test_reset;
      RST_N     = 1'b0;
      IN_VALID  = 1'b0;
      OP        = OP_ADD;
      OPND      = '0;
      CLEAR     = 1'b0;
      OUT_READY = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      n_cmp++;
      if ({OUT_VALID, CO, OVF, ACC_OUT} !== 35'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v%b co%b ovf%b acc %h want all 0",
                  OUT_VALID, CO, OVF, ACC_OUT);
      end
      RST_N = 1'b1;
      @(negedge CLK);
      n_cmp++;
      if (IN_READY !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b want 1", IN_READY);
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic test_carry_cascade;
      logic [33:0] g;
      got_q.delete();
      exp_q = '{34'h0_0000FFFF, 34'h0_00010000};
      send(OP_LOAD, 32'h0000_FFFF);
      send(OP_ADD,  32'h0000_0001);
      wait_got(2);
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         g = got_q.pop_front();
         n_cmp++;
         if (g !== exp_q[0]) begin
            n_fail++;
            $display("FAIL carry_cascade: got %h want %h", g, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_borrow;
      logic [33:0] g;
      got_q.delete();
      exp_q = '{34'h0_00000000, 34'h1_FFFFFFFF};
      send(OP_LOAD, 32'h0000_0000);
      send(OP_SUB,  32'h0000_0001);
      wait_got(2);
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         g = got_q.pop_front();
         n_cmp++;
         if (g !== exp_q[0]) begin
            n_fail++;
            $display("FAIL borrow: got %h want %h", g, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_overflow_sticky;
      logic [33:0] g;
      got_q.delete();
      exp_q = '{34'h0_7FFFFFFF, 34'h2_80000000, 34'h2_80000000};
      send(OP_LOAD, 32'h7FFF_FFFF);
      send(OP_ADD,  32'h0000_0001);
      send(OP_HOLD, 32'hDEAD_BEEF);
      wait_got(3);
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         g = got_q.pop_front();
         n_cmp++;
         if (g !== exp_q[0]) begin
            n_fail++;
            $display("FAIL overflow_sticky: got %h want %h", g, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
      idle(2);
      CLEAR = 1'b1;
      @(negedge CLK);
      n_cmp++;
      if (IN_READY !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_in_ready: got %b want 0", IN_READY);
      end
      @(posedge CLK);
      #1;
      CLEAR = 1'b0;
      @(negedge CLK);
      n_cmp++;
      if (OVF !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_ovf: got %b want 0", OVF);
      end
      @(posedge CLK);
      #1;
      exp_q = '{34'h0_00000000};
      send(OP_LOAD, 32'h0000_0000);
      wait_got(1);
      if (got_q.size() > 0) begin
         g = got_q.pop_front();
         n_cmp++;
         if (g !== exp_q[0]) begin
            n_fail++;
            $display("FAIL after_clear_load: got %h want %h", g, exp_q[0]);
         end
      end
   endtask

   task automatic test_stall;
      logic [33:0] g;
      got_q.delete();
      exp_q = '{34'h0_00010001, 34'h0_00020000, 34'h0_0001FFFD};
      OUT_READY = 1'b0;
      fork
         begin
            send(OP_ADD, 32'h0001_0001);
            send(OP_ADD, 32'h0000_FFFF);
            send(OP_SUB, 32'h0000_0003);
         end
         begin
            repeat (2) @(negedge CLK);
            for (int c = 0; c < 5; c++) begin
               @(negedge CLK);
               n_cmp++;
               if (IN_READY !== 1'b0) begin
                  n_fail++;
                  $display("FAIL stall_in_ready: cycle %0d got %b want 0", c, IN_READY);
               end
               n_cmp++;
               if (OUT_VALID !== 1'b1 || ACC_OUT !== 32'h0001_0001) begin
                  n_fail++;
                  $display("FAIL stall_hold: cycle %0d got v%b acc %h want v1 acc 00010001",
                           c, OUT_VALID, ACC_OUT);
               end
            end
            @(posedge CLK);
            #1;
            OUT_READY = 1'b1;
         end
      join
      wait_got(3);
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         g = got_q.pop_front();
         n_cmp++;
         if (g !== exp_q[0]) begin
            n_fail++;
            $display("FAIL stall_release: got %h want %h", g, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
      idle(3);
      n_cmp++;
      if (got_q.size() !== 0) begin
         n_fail++;
         $display("FAIL stall_extra: extra beats got %0d want 0", got_q.size());
      end
   endtask

   task automatic test_clear_flush;
      logic [33:0] g;
      got_q.delete();
      OUT_READY = 1'b0;
      send(OP_ADD, 32'h0000_0001);
      send(OP_ADD, 32'h0000_0002);
      CLEAR = 1'b1;
      @(negedge CLK);
      n_cmp++;
      if (OUT_VALID !== 1'b1 || IN_READY !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_pre: got v%b rdy%b want v1 rdy0", OUT_VALID, IN_READY);
      end
      @(posedge CLK);
      #1;
      CLEAR     = 1'b0;
      OUT_READY = 1'b1;
      @(negedge CLK);
      n_cmp++;
      if (OUT_VALID !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_valid: got %b want 0", OUT_VALID);
      end
      @(posedge CLK);
      #1;
      send(OP_ADD, 32'h0000_0005);
      wait_got(1);
      if (got_q.size() > 0) begin
         g = got_q.pop_front();
         n_cmp++;
         if (g !== 34'h0_00000005) begin
            n_fail++;
            $display("FAIL flush_next_add: got %h want %h", g, 34'h0_00000005);
         end
      end
      idle(3);
      n_cmp++;
      if (got_q.size() !== 0) begin
         n_fail++;
         $display("FAIL flush_extra: extra beats got %0d want 0", got_q.size());
      end
   endtask

   task automatic test_async_reset;
      OUT_READY = 1'b1;
      send(OP_LOAD, 32'h1111_1111);
      send(OP_ADD,  32'h2222_2222);
      #2;
      RST_N = 1'b0;
      #1;
      n_cmp++;
      if ({OUT_VALID, CO, OVF, ACC_OUT} !== 35'h0) begin
         n_fail++;
         $display("FAIL async_reset: got v%b co%b ovf%b acc %h want all 0",
                  OUT_VALID, CO, OVF, ACC_OUT);
      end
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      got_q.delete();
      IN_VALID = 1'b1;
      OP       = OP_LOAD;
      OPND     = 32'h1234_5678;
      @(negedge CLK);
      n_cmp++;
      if (IN_READY !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset_ready: got %b want 1", IN_READY);
      end
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
      @(negedge CLK);
      n_cmp++;
      if (OUT_VALID !== 1'b0) begin
         n_fail++;
         $display("FAIL latency_early: OUT_VALID got %b want 0", OUT_VALID);
      end
      @(negedge CLK);
      n_cmp++;
      if (OUT_VALID !== 1'b1 || ACC_OUT !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL latency_result: got v%b acc %h want v1 acc 12345678",
                  OUT_VALID, ACC_OUT);
      end
      idle(2);
   endtask

   initial begin
      test_reset();
      test_carry_cascade();
      test_borrow();
      test_overflow_sticky();
      test_stall();
      test_clear_flush();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
